// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver and its baud tick.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    localparam int OVERSAMPLE_DEF = 16;

    // Clocks per sample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    // Mid-bit sample index; the majority window is mid-1 .. mid+1.
    function automatic int calc_mid(input int oversample);
        return oversample / 2;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable down-counter producing a one-cycle tick every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count down to terminal count, reload and pulse; restart realigns the phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= RELOAD;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= RELOAD;
            tick <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= RELOAD;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-voted mid-bit sampling, valid/ready output,
// per-frame framing/parity status and sticky overrun.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | validating start bit at mid-bit
// DATA   | shifting in payload bits, LSB first
// PARITY | capturing parity bit
// STOP   | mid-bit stop decision, frame delivered
// BREAK  | stop bit was low, wait for line to return high
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int M   = calc_mid(OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MM1  = SW'(M - 1);
    localparam logic [SW-1:0] S_MID  = SW'(M);
    localparam logic [SW-1:0] S_MP1  = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

    uart_state_t state, state_nxt;

    logic          rx_s1, rx_s2;
    logic          tick, restart;
    logic [SW-1:0] s_cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    samp;
    logic          maj, at_mid, at_last;
    logic          shift_en, par_cap, deliver;
    logic          deliver_req, pend_ferr, par_bit;
    logic [7:0]    shreg, rx_byte;
    logic          par_exp, perr;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    assign maj     = (samp[1] & samp[0]) | (samp[1] & rx_s2) | (samp[0] & rx_s2);
    assign at_mid  = tick && (s_cnt == S_MP1);
    assign at_last = tick && (s_cnt == S_LAST);
    assign rx_byte = shreg >> (8 - DATA_BITS);
    assign par_exp = (^rx_byte) ^ (PARITY_ODD != 0);
    assign perr    = (PARITY_EN != 0) && (par_bit != par_exp);
    assign busy    = (state != IDLE);

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        shift_en  = 1'b0;
        par_cap   = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: if (!rx_s2) begin
                state_nxt = START;
                restart   = 1'b1;
            end
            START: begin
                if (at_mid && maj) state_nxt = IDLE;
                else if (at_last)  state_nxt = DATA;
            end
            DATA: begin
                shift_en = at_mid;
                if (at_last && bit_cnt == B_LAST)
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                par_cap = at_mid;
                if (at_last) state_nxt = STOP;
            end
            // Leave at mid-bit so a back-to-back start edge is not missed.
            STOP: if (at_mid) begin
                deliver   = 1'b1;
                state_nxt = maj ? IDLE : BREAK;
            end
            BREAK: if (rx_s2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sample/bit counters, majority window and payload shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_cnt   <= '0;
            bit_cnt <= '0;
            samp    <= 2'b11;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (state == IDLE)
                s_cnt <= '0;
            else if (tick)
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
            if (state != DATA)
                bit_cnt <= '0;
            else if (at_last)
                bit_cnt <= bit_cnt + 1'b1;
            if (tick && (s_cnt == S_MM1 || s_cnt == S_MID))
                samp <= {samp[0], rx_s2};
            if (shift_en) shreg   <= {maj, shreg[7:1]};
            if (par_cap)  par_bit <= maj;
        end
    end

    // Delivery one cycle after the stop decision, plus valid/ready handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deliver_req <= 1'b0;
            pend_ferr   <= 1'b0;
            data_out    <= '0;
            rx_valid    <= 1'b0;
            rx_done     <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            deliver_req <= deliver;
            if (deliver) pend_ferr <= ~maj;
            rx_done <= 1'b0;
            if (rx_valid && rx_ready) overrun <= 1'b0;
            if (deliver_req) begin
                if (!rx_valid || rx_ready) begin
                    data_out   <= rx_byte;
                    frame_err  <= pend_ferr;
                    parity_err <= perr;
                    rx_valid   <= 1'b1;
                    rx_done    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1 unit plus an even-parity unit.
module tb_uart_rx_os;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       line;
    int         sel;
    logic       rx_a, rx_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, done_a, done_b;
    logic       ferr_a, ferr_b, perr_a, perr_b, ovr_a, ovr_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_done_a = 0;
    int cnt_done_b = 0;
    int snap;

    assign rx_a = (sel == 0) ? line : 1'b1;
    assign rx_b = (sel == 1) ? line : 1'b1;

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_ready(ready_a),
        .data_out(data_a), .rx_valid(valid_a), .rx_done(done_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_ready(ready_b),
        .data_out(data_b), .rx_valid(valid_b), .rx_done(done_b),
        .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b), .busy(busy_b)
    );

    always @(posedge clk) begin
        if (done_a) cnt_done_a <= cnt_done_a + 1;
        if (done_b) cnt_done_b <= cnt_done_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        line = v;
        wait_clk(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic par_on, input logic par_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_on) send_bit(par_v);
        send_bit(stop_v);
    endtask

    task automatic pulse_ready(input int s);
        @(negedge clk);
        if (s == 0) ready_a = 1'b1;
        else        ready_b = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    initial begin
        rst = 1'b0; line = 1'b1; sel = 0; ready_a = 1'b0; ready_b = 1'b0;
        wait_clk(5);
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_data", data_a, 0);
        check("rst_overrun", ovr_a, 0);
        rst = 1'b1;
        wait_clk(20);

        // 1: 0xA5 8N1, consumer not ready
        snap = cnt_done_a;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_clk(20);
        check("t1_data", data_a, 8'hA5);
        check("t1_valid", valid_a, 1);
        check("t1_done_cnt", cnt_done_a - snap, 1);
        check("t1_ferr", ferr_a, 0);
        check("t1_perr", perr_a, 0);
        check("t1_overrun", ovr_a, 0);
        pulse_ready(0);
        check("t1_consumed", valid_a, 0);

        // 2: 40-clock low glitch is a false start
        snap = cnt_done_a;
        line = 1'b0;
        wait_clk(40);
        line = 1'b1;
        check("t2_busy_during", busy_a, 1);
        wait_clk(200);
        check("t2_busy_after", busy_a, 0);
        check("t2_valid", valid_a, 0);
        check("t2_done_cnt", cnt_done_a - snap, 0);

        // 3: 0x3C with low stop bit, line then held low
        snap = cnt_done_a;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_clk(320);
        check("t3_data", data_a, 8'h3C);
        check("t3_ferr", ferr_a, 1);
        check("t3_valid", valid_a, 1);
        check("t3_busy_break", busy_a, 1);
        line = 1'b1;
        wait_clk(300);
        check("t3_busy_idle", busy_a, 0);
        check("t3_done_cnt", cnt_done_a - snap, 1);
        pulse_ready(0);
        check("t3_consumed", valid_a, 0);

        // 4: even parity unit, 0x07 needs parity bit 1
        sel = 1;
        wait_clk(20);
        snap = cnt_done_b;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        wait_clk(20);
        check("t4_bad_data", data_b, 8'h07);
        check("t4_bad_perr", perr_b, 1);
        check("t4_bad_ferr", ferr_b, 0);
        check("t4_bad_valid", valid_b, 1);
        pulse_ready(1);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        wait_clk(20);
        check("t4_good_data", data_b, 8'h07);
        check("t4_good_perr", perr_b, 0);
        check("t4_good_valid", valid_b, 1);
        check("t4_done_cnt", cnt_done_b - snap, 2);
        check("t4_a_quiet", valid_a, 0);
        pulse_ready(1);
        sel = 0;
        wait_clk(20);

        // 5: back-to-back frames with no consumer -> overrun
        snap = cnt_done_a;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        wait_clk(20);
        check("t5_data", data_a, 8'h11);
        check("t5_overrun", ovr_a, 1);
        check("t5_valid", valid_a, 1);
        check("t5_done_cnt", cnt_done_a - snap, 1);
        pulse_ready(0);
        check("t5_valid_clr", valid_a, 0);
        check("t5_overrun_clr", ovr_a, 0);

        // 6: reset during data bit 4 of 0xFF, then a clean 0x5A
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        line = 1'b1;
        wait_clk(80);
        check("t6_busy_pre", busy_a, 1);
        rst = 1'b0;
        #1;
        check("t6_rst_busy", busy_a, 0);
        check("t6_rst_data", data_a, 0);
        check("t6_rst_valid", valid_a, 0);
        check("t6_rst_ovr", ovr_a, 0);
        wait_clk(10);
        rst = 1'b1;
        wait_clk(20);
        snap = cnt_done_a;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        wait_clk(20);
        check("t6_data", data_a, 8'h5A);
        check("t6_valid", valid_a, 1);
        check("t6_ferr", ferr_a, 0);
        check("t6_perr", perr_a, 0);
        check("t6_overrun", ovr_a, 0);
        check("t6_done_cnt", cnt_done_a - snap, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
